rr_arbiter_8: RTL and testbench

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

---
 rtl/rr_arbiter_8.sv | 125 ++++++++++++
 tb/tb_rr_arbiter_8.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with a rotating priority pointer, done-driven release
// and a watchdog that force-releases a grant held for MAX_HOLD cycles.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] grant_q, grant_d;
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;
    logic       timeout_q, timeout_d;

    logic [7:0] arb_req;
    logic [7:0] rot_req;
    logic [7:0] win_onehot;
    logic [2:0] win_off;
    logic [2:0] winner;
    logic       win_any;
    logic       do_arb;

    // While busy the holder is masked so a release never re-grants the same requester.
    assign arb_req = (state_q == BUSY) ? (req & ~grant_q) : req;
    assign win_any = |arb_req;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi]    = arb_req[ptr_q + 3'(gi)];
            assign win_onehot[gi] = (winner == 3'(gi));
        end
    endgenerate

    always_comb begin
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) win_off = 3'(i);
        end
    end

    assign winner = ptr_q + win_off;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        do_arb    = 1'b0;

        case (state_q)
            IDLE: begin
                do_arb = 1'b1;
            end
            BUSY: begin
                if (done) begin
                    do_arb = 1'b1;
                end else if (hold_q == 8'(MAX_HOLD - 1)) begin
                    do_arb    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_arb) begin
            hold_d = 8'd0;
            if (win_any) begin
                state_d = BUSY;
                idx_d   = winner;
                grant_d = win_onehot;
                valid_d = 1'b1;
                ptr_d   = winner + 3'd1;
            end else begin
                state_d = IDLE;
                idx_d   = 3'd0;
                grant_d = 8'h00;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            grant_q   <= 8'h00;
            hold_q    <= 8'd0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8 (MAX_HOLD = 4): each stimulus cycle queues the
// hand-computed outputs expected after the following edge; a monitor pops and compares.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    typedef struct {
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic       to;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic [7:0] rq, input logic d,
                        input logic v, input logic [2:0] idx, input logic to,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = d;
        e.v    = v;
        e.idx  = idx;
        e.to   = to;
        e.g    = v ? (8'h01 << idx) : 8'h00;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: compare the full output bundle one time unit after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({grant, grant_idx, grant_valid, timeout} !== {e.g, e.idx, e.v, e.to}) begin
                    errors++;
                    $display("FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, want grant=%h idx=%0d valid=%b timeout=%b",
                             e.name, grant, grant_idx, grant_valid, timeout, e.g, e.idx, e.v, e.to);
                end else begin
                    $display("ok   %s: grant=%h idx=%0d valid=%b timeout=%b",
                             e.name, grant, grant_idx, grant_valid, timeout);
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;

        // reset state and reset priority over inputs
        step(1, 8'h00, 0, 0, 3'd0, 0, "reset");
        step(1, 8'hFF, 1, 0, 3'd0, 0, "reset_override");

        // single request, release, done ignored while idle
        step(0, 8'h01, 0, 1, 3'd0, 0, "single_grant");
        step(0, 8'h00, 1, 0, 3'd0, 0, "single_release");
        step(0, 8'h00, 1, 0, 3'd0, 0, "idle_done_ignored");

        // full rotation with back-to-back grants
        step(1, 8'h00, 0, 0, 3'd0, 0, "reset2");
        step(0, 8'hFF, 0, 1, 3'd0, 0, "rot0");
        for (int k = 1; k <= 8; k++) begin
            step(0, 8'hFF, 1, 1, 3'(k % 8), 0, $sformatf("rot%0d", k));
        end
        step(0, 8'h00, 1, 0, 3'd0, 0, "rot_end");

        // wrap-around: ptr = 6 after granting 5
        step(0, 8'h20, 0, 1, 3'd5, 0, "grant5");
        step(0, 8'h03, 1, 1, 3'd0, 0, "wrap0");
        step(0, 8'h03, 1, 1, 3'd1, 0, "wrap1");
        step(0, 8'h00, 1, 0, 3'd0, 0, "wrap_end");

        // watchdog: sole requester held 4 cycles, then timeout to idle
        for (int k = 0; k < 4; k++) begin
            step(0, 8'h04, 0, 1, 3'd2, 0, $sformatf("hold%0d", k));
        end
        step(0, 8'h04, 0, 0, 3'd0, 1, "timeout_idle");
        step(0, 8'h04, 0, 1, 3'd2, 0, "regrant_after_timeout");

        // done on the final hold cycle wins over expiry
        for (int k = 1; k < 4; k++) begin
            step(0, 8'h04, 0, 1, 3'd2, 0, $sformatf("rehold%0d", k));
        end
        step(0, 8'h04, 1, 0, 3'd0, 0, "done_at_expiry");

        // holder drops req mid-grant, timeout hands grant straight to another requester
        step(0, 8'h44, 0, 1, 3'd6, 0, "grant6");
        for (int k = 1; k < 4; k++) begin
            step(0, 8'h04, 0, 1, 3'd6, 0, $sformatf("holder_drop%0d", k));
        end
        step(0, 8'h04, 0, 1, 3'd2, 1, "timeout_regrant");
        step(0, 8'h00, 1, 0, 3'd0, 0, "release");

        // reset mid-grant, then arbitration restarts from ptr = 0
        step(0, 8'h20, 0, 1, 3'd5, 0, "grant5_again");
        step(1, 8'h20, 0, 0, 3'd0, 0, "rst_mid_grant");
        step(0, 8'h20, 0, 1, 3'd5, 0, "post_rst_grant5");
        step(0, 8'hFF, 1, 1, 3'd6, 0, "after5_grant6");
        step(1, 8'h00, 0, 0, 3'd0, 0, "reset3");
        step(0, 8'h41, 0, 1, 3'd0, 0, "ptr_zero_after_rst");

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1);
    end

endmodule
